// File: rtl/exti_arbiter_if.sv
// Handshake and bus signals between the EXTI arbiter (master) and the
// board pins / microcode sequencer side (slave).
interface exti_arbiter_if;
    logic [3:0] exti_n;
    logic       en_we;
    logic [3:0] en_d;
    logic       ack;
    logic       done;
    logic       req;
    logic [3:0] vec;
    logic [3:0] pend;
    logic       busy;

    modport master (
        input  exti_n, en_we, en_d, ack, done,
        output req, vec, pend, busy
    );

    modport slave (
        output exti_n, en_we, en_d, ack, done,
        input  req, vec, pend, busy
    );
endinterface

// File: rtl/exti_arbiter.sv
// External interrupt arbiter: synchronises EXTI lines, latches falling edges
// as pending requests and grants one enabled line at a time via req/ack/done.
module exti_arbiter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          ROUND_ROBIN = 1'b0,
    parameter logic [3:0]  EN_RESET    = 4'b0000
) (
    input  logic           irq_clk,
    input  logic           init_n,
    exti_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        SERVICE
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] sync_q [SYNC_STAGES];
    logic [3:0] hist_q;
    logic [3:0] fall;
    logic [3:0] pend_q, pend_d;
    logic [3:0] en_q;
    logic [3:0] vec_q, vec_d;
    logic [1:0] gnt_q, gnt_d;
    logic [1:0] last_q, last_d;
    logic [3:0] clr;
    logic [3:0] cand;
    logic [1:0] start;
    logic [1:0] idx;
    logic [1:0] win_idx;
    logic       found;

    // Synchroniser chain plus history flop; all ones so a line held low
    // through reset still yields exactly one edge after release.
    always_ff @(posedge irq_clk) begin
        if (!init_n) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '1;
            end
            hist_q <= '1;
        end else begin
            sync_q[0] <= bus.exti_n;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign fall = ~sync_q[SYNC_STAGES-1] & hist_q;

    // Cyclic descending search; fixed mode is the same search pinned at bit 3.
    always_comb begin
        cand    = pend_q & en_q;
        start   = ROUND_ROBIN ? (last_q - 2'd1) : 2'd3;
        found   = 1'b0;
        win_idx = '0;
        idx     = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            idx = start - k[1:0];
            if (!found && cand[idx]) begin
                found   = 1'b1;
                win_idx = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        clr     = '0;
        case (state_q)
            IDLE: begin
                vec_d = '0;
                if (found) begin
                    state_d = GRANT;
                    vec_d   = 4'b0001 << win_idx;
                    gnt_d   = win_idx;
                end
            end
            GRANT: begin
                if (bus.ack) begin
                    clr     = vec_q;
                    last_d  = gnt_q;
                    state_d = SERVICE;
                end
            end
            SERVICE: begin
                if (bus.done) begin
                    state_d = IDLE;
                    vec_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                vec_d   = '0;
            end
        endcase
        // A new edge on the line being acked survives the clear.
        pend_d = (pend_q & ~clr) | fall;
    end

    always_ff @(posedge irq_clk) begin
        if (!init_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            en_q    <= EN_RESET;
            vec_q   <= '0;
            gnt_q   <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            vec_q   <= vec_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            if (bus.en_we) begin
                en_q <= bus.en_d;
            end
        end
    end

    assign bus.req  = (state_q == GRANT);
    assign bus.busy = (state_q == SERVICE);
    assign bus.vec  = vec_q;
    assign bus.pend = pend_q;

endmodule

// File: tb/tb_exti_arbiter.sv
// Randomised bench for exti_arbiter: a fixed-priority and a rotating-priority
// instance share stimulus and are compared every cycle with behavioural models.
module tb_exti_arbiter;

    logic       clk = 1'b0;
    logic       init_n_t = 1'b0;
    logic [3:0] exti_n_t = 4'hF;
    logic       en_we_t = 1'b0;
    logic [3:0] en_d_t = 4'h0;
    logic       ack_t = 1'b0;
    logic       done_t = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    exti_arbiter_if if_f ();
    exti_arbiter_if if_r ();

    assign if_f.exti_n = exti_n_t;
    assign if_f.en_we  = en_we_t;
    assign if_f.en_d   = en_d_t;
    assign if_f.ack    = ack_t;
    assign if_f.done   = done_t;
    assign if_r.exti_n = exti_n_t;
    assign if_r.en_we  = en_we_t;
    assign if_r.en_d   = en_d_t;
    assign if_r.ack    = ack_t;
    assign if_r.done   = done_t;

    exti_arbiter #(
        .SYNC_STAGES(2),
        .ROUND_ROBIN(1'b0),
        .EN_RESET(4'b0000)
    ) dut_fix (
        .irq_clk(clk),
        .init_n(init_n_t),
        .bus(if_f.master)
    );

    exti_arbiter #(
        .SYNC_STAGES(3),
        .ROUND_ROBIN(1'b1),
        .EN_RESET(4'b1010)
    ) dut_rr (
        .irq_clk(clk),
        .init_n(init_n_t),
        .bus(if_r.master)
    );

    // Reference model: per instance, a delay line of sampled pin values,
    // pending/enable words, and the handshake phase (0 idle, 1 offered, 2 serving).
    int unsigned s_p   [2] = '{2, 3};
    bit          rr_p  [2] = '{1'b0, 1'b1};
    logic [3:0]  enr_p [2] = '{4'b0000, 4'b1010};
    logic [3:0]  m_x   [2][5];
    logic [3:0]  m_pend [2];
    logic [3:0]  m_en   [2];
    int          m_phase [2];
    int          m_g     [2];
    int          m_last  [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input int j);
        logic [3:0] set;
        logic [3:0] clr;
        logic [3:0] cand;
        int         line;
        bit         hit;
        if (!init_n_t) begin
            for (int d = 0; d < 5; d++) m_x[j][d] = 4'hF;
            m_pend[j]  = 4'h0;
            m_en[j]    = enr_p[j];
            m_phase[j] = 0;
            m_g[j]     = 0;
            m_last[j]  = 0;
        end else begin
            // Falling edge seen by the core when the value sampled S edges ago
            // is low and the one before it was high.
            set = ~m_x[j][s_p[j]-1] & m_x[j][s_p[j]];
            for (int d = 4; d > 0; d--) m_x[j][d] = m_x[j][d-1];
            m_x[j][0] = exti_n_t;
            clr = 4'h0;
            if (m_phase[j] == 1) begin
                if (ack_t) begin
                    clr[m_g[j]] = 1'b1;
                    m_last[j]   = m_g[j];
                    m_phase[j]  = 2;
                end
            end else if (m_phase[j] == 2) begin
                if (done_t) m_phase[j] = 0;
            end else begin
                cand = m_pend[j] & m_en[j];
                hit  = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    line = rr_p[j] ? ((m_last[j] + 3 - k) % 4) : (3 - k);
                    if (!hit && cand[line]) begin
                        hit        = 1'b1;
                        m_g[j]     = line;
                        m_phase[j] = 1;
                    end
                end
            end
            m_pend[j] = (m_pend[j] & ~clr) | set;
            if (en_we_t) m_en[j] = en_d_t;
        end
    endtask

    function automatic logic [31:0] model_word(input int j);
        logic [3:0] v;
        v = (m_phase[j] != 0) ? (4'b0001 << m_g[j]) : 4'b0000;
        return {22'd0, m_phase[j] == 1, m_phase[j] == 2, v, m_pend[j]};
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check("fix", {22'd0, if_f.req, if_f.busy, if_f.vec, if_f.pend}, model_word(0));
        check("rr",  {22'd0, if_r.req, if_r.busy, if_r.vec, if_r.pend}, model_word(1));
    endtask

    // Sequencer behaviour for directed phases: ack an offer, finish at once.
    task automatic serve_steps(input int n);
        for (int i = 0; i < n; i++) begin
            ack_t  = if_f.req;
            done_t = if_f.busy;
            step();
        end
        ack_t  = 1'b0;
        done_t = 1'b0;
    endtask

    int hold [4];

    initial begin
        init_n_t = 1'b0;
        step();
        step();
        check("rst_fix", {22'd0, if_f.req, if_f.busy, if_f.vec, if_f.pend}, 32'd0);
        init_n_t = 1'b1;
        step();

        // EXTI4_n low for three cycles with everything disabled.
        exti_n_t = 4'b1011;
        step(); step(); step();
        check("exti4_pend", {28'd0, if_f.pend}, 32'h4);
        exti_n_t = 4'hF;
        step(); step();
        check("exti4_no_req", {31'd0, if_f.req}, 32'd0);

        en_we_t = 1'b1;
        en_d_t  = 4'b1111;
        step();
        en_we_t = 1'b0;
        step();
        check("en_grant", {27'd0, if_f.req, if_f.vec}, {27'd0, 1'b1, 4'h4});
        serve_steps(8);

        // All four lines fall together; fixed grants come out 8, 4, 2, 1.
        exti_n_t = 4'h0;
        serve_steps(3);
        exti_n_t = 4'hF;
        serve_steps(30);
        check("all_pend_zero", {28'd0, if_f.pend}, 32'd0);

        for (int i = 0; i < 4; i++) hold[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) begin
                hold[i]++;
                if (hold[i] >= 2 && $urandom_range(5, 0) == 0) begin
                    exti_n_t[i] = ~exti_n_t[i];
                    hold[i] = 0;
                end
            end
            ack_t    = ($urandom_range(2, 0) == 0);
            done_t   = ($urandom_range(2, 0) == 0);
            en_we_t  = ($urandom_range(19, 0) == 0);
            en_d_t   = 4'($urandom_range(15, 0));
            init_n_t = ($urandom_range(149, 0) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
